// File: rtl/vram_arbiter.sv
// Shares the single VRAM host port between the CPU bus and the VRAM DMA engine.
// Fair round-robin outside vblank; bounded DMA burst lock during vblank.
module vram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_win_q, last_win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cpu_pri_q, cpu_pri_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_sel_q, rd_sel_d;

  // Grant selection and next-state for the lock FSM
  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    cnt_d      = cnt_q;
    cpu_pri_d  = cpu_pri_q;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    cnt_inc    = cnt_q + CNT_W'(1);

    if (rst) begin
      state_d = ARB;
    end else if ((state_q == LOCK) && vblank) begin
      if (dma_req) begin
        dma_gnt    = 1'b1;
        last_win_d = 1'b1;
        // The cap takes precedence so the CPU always gets the slot after a full lock
        if (cnt_inc == CNT_W'(BURST_MAX)) begin
          state_d   = ARB;
          cnt_d     = '0;
          cpu_pri_d = 1'b1;
        end else if (dma_last) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (cpu_req) begin
        cpu_gnt    = 1'b1;
        last_win_d = 1'b0;
      end else begin
        cpu_gnt = 1'b0;
      end
    end else begin
      // Plain arbitration, also used on the cycle vblank drops while locked
      state_d   = ARB;
      cnt_d     = '0;
      cpu_pri_d = 1'b0;
      if (cpu_req && dma_req) begin
        if (cpu_pri_q) begin
          cpu_gnt = 1'b1;
        end else if (vblank) begin
          dma_gnt = 1'b1;
        end else if (last_win_q) begin
          cpu_gnt = 1'b1;
        end else begin
          dma_gnt = 1'b1;
        end
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end else begin
        cpu_gnt = 1'b0;
      end

      if (dma_gnt) begin
        last_win_d = 1'b1;
        if (vblank && !dma_last) begin
          state_d = LOCK;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ARB;
        end
      end else if (cpu_gnt) begin
        last_win_d = 1'b0;
      end else begin
        last_win_d = last_win_q;
      end
    end
  end

  // VRAM port mux and read-return tracking
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (dma_gnt) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
    end else if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else begin
      mem_we = 1'b0;
    end
    rd_pend_d = mem_en & ~mem_we;
    rd_sel_d  = dma_gnt;
  end

  // Route last cycle's read data to its requester; reset drops a pending return
  always_comb begin
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    cpu_rdata  = '0;
    dma_rdata  = '0;
    if (rst) begin
      cpu_rvalid = 1'b0;
    end else if (rd_pend_q && rd_sel_q) begin
      dma_rvalid = 1'b1;
      dma_rdata  = mem_dout;
    end else if (rd_pend_q) begin
      cpu_rvalid = 1'b1;
      cpu_rdata  = mem_dout;
    end else begin
      cpu_rvalid = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      last_win_q <= 1'b1;
      cnt_q      <= '0;
      cpu_pri_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      cnt_q      <= cnt_d;
      cpu_pri_q  <= cpu_pri_d;
      rd_pend_q  <= rd_pend_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

endmodule
